program_loader: RTL and testbench

Boot-time program loader sitting directly upstream of `memory`. It consumes a framed byte stream (valid/ready), assembles bytes into `WIDTH`-bit words and drives a dedicated memory write port. It holds the processor in a stopped state (`run`=0) until a complete frame with a correct checksum has been received. This replaces the hard-coded RAM image written at reset.

---
 rtl/tiny_pkg.sv | 21 ++
 rtl/loader_word_pack.sv | 48 ++++
 rtl/program_loader.sv | 126 ++++++++++++
 tb/tb_program_loader.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/tiny_pkg.sv
// Shared types and constants for the boot-time program loader.
// Holds the loader FSM state encoding, the frame header byte and the
// width of the little-endian address/count fields.
package tiny_pkg;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_ADDR_LO,
        ST_ADDR_HI,
        ST_CNT_LO,
        ST_CNT_HI,
        ST_DATA,
        ST_CHECK,
        ST_DONE,
        ST_ERROR
    } loader_state_t;

    localparam logic [7:0] LOADER_HEADER      = 8'hA5;
    localparam int         LOADER_FIELD_BYTES = 2;

endpackage

// File: rtl/loader_word_pack.sv
// Byte-to-word assembler: places each accepted byte into the word from the LSB upward.
// Ports: clk/reset, i_clear (restart at byte 0), i_byte_vld/i_byte (accepted byte),
//        o_word (word including the current byte), o_word_done (current byte completes a word).
module loader_word_pack #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_clear,
    input  logic             i_byte_vld,
    input  logic [7:0]       i_byte,
    output logic [WIDTH-1:0] o_word,
    output logic             o_word_done
);

    localparam int BPW = WIDTH / 8;
    localparam int CW  = (BPW > 1) ? $clog2(BPW) : 1;

    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_word;

    // The current byte is merged combinationally so the completed word is
    // available in the same cycle its final byte is accepted.
    always_comb begin
        o_word = r_word;
        for (int b = 0; b < BPW; b++) begin
            if (r_cnt == CW'(b)) begin
                o_word[b*8 +: 8] = i_byte;
            end
        end
    end

    assign o_word_done = i_byte_vld && (r_cnt == CW'(BPW - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt  <= '0;
            r_word <= '0;
        end else if (i_clear) begin
            r_cnt  <= '0;
            r_word <= '0;
        end else if (i_byte_vld) begin
            r_word <= o_word;
            r_cnt  <= o_word_done ? '0 : r_cnt + CW'(1);
        end
    end

endmodule

// File: rtl/program_loader.sv
// Boot loader: parses A5/addr/cnt/data/chk frames, writes words to memory, releases run on a good checksum.
// Ports: clk/reset, in_valid/in_data/in_ready byte stream, wr_en/wr_addr/wr_data memory write port,
//        busy (frame in progress), run (sticky, program loaded), error (last frame failed checksum).
module program_loader
    import tiny_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    input  logic [7:0]       in_data,
    output logic             in_ready,
    output logic             wr_en,
    output logic [WIDTH-1:0] wr_addr,
    output logic [WIDTH-1:0] wr_data,
    output logic             busy,
    output logic             run,
    output logic             error
);

    localparam int FW = LOADER_FIELD_BYTES * 8;

    loader_state_t    r_state;
    loader_state_t    w_next;
    logic [WIDTH-1:0] r_addr;
    logic [WIDTH-1:0] r_cnt;
    logic [7:0]       r_sum;

    logic             w_acc;
    logic             w_hdr;
    logic             w_in_data_st;
    logic [FW-1:0]    w_addr_full;
    logic [FW-1:0]    w_cnt_full;
    logic [WIDTH-1:0] w_addr_field;
    logic [WIDTH-1:0] w_cnt_field;
    logic [WIDTH-1:0] w_word;
    logic             w_word_done;

    assign in_ready = (r_state != ST_DONE);
    assign w_acc    = in_valid && in_ready;
    // A header restarts a frame from IDLE or after a checksum failure.
    assign w_hdr    = w_acc && (in_data == LOADER_HEADER) &&
                      ((r_state == ST_IDLE) || (r_state == ST_ERROR));
    assign w_in_data_st = (r_state == ST_DATA);

    // Hi byte joins the stored lo byte; truncation drops it when WIDTH is 8.
    assign w_addr_full  = {in_data, r_addr[7:0]};
    assign w_cnt_full   = {in_data, r_cnt[7:0]};
    assign w_addr_field = w_addr_full[WIDTH-1:0];
    assign w_cnt_field  = w_cnt_full[WIDTH-1:0];

    loader_word_pack #(.WIDTH(WIDTH)) u_pack (
        .clk         (clk),
        .reset       (reset),
        .i_clear     (w_hdr),
        .i_byte_vld  (w_acc && w_in_data_st),
        .i_byte      (in_data),
        .o_word      (w_word),
        .o_word_done (w_word_done)
    );

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE, ST_ERROR: if (w_hdr) w_next = ST_ADDR_LO;
            ST_ADDR_LO:        if (w_acc) w_next = ST_ADDR_HI;
            ST_ADDR_HI:        if (w_acc) w_next = ST_CNT_LO;
            ST_CNT_LO:         if (w_acc) w_next = ST_CNT_HI;
            ST_CNT_HI:         if (w_acc) w_next = (w_cnt_field == '0) ? ST_CHECK : ST_DATA;
            ST_DATA:           if (w_word_done && (r_cnt == WIDTH'(1))) w_next = ST_CHECK;
            ST_CHECK:          if (w_acc) w_next = (in_data == r_sum) ? ST_DONE : ST_ERROR;
            ST_DONE:           w_next = ST_DONE;
            default:           w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_addr  <= '0;
            r_cnt   <= '0;
            r_sum   <= '0;
            wr_en   <= 1'b0;
            wr_addr <= '0;
            wr_data <= '0;
        end else begin
            wr_en <= 1'b0;
            if (w_hdr) begin
                r_sum <= '0;
            end else if (w_acc && (r_state inside {ST_ADDR_LO, ST_ADDR_HI, ST_CNT_LO,
                                                   ST_CNT_HI, ST_DATA})) begin
                r_sum <= r_sum + in_data;
            end
            if (w_acc) begin
                case (r_state)
                    ST_ADDR_LO: r_addr <= WIDTH'(in_data);
                    ST_ADDR_HI: r_addr <= w_addr_field;
                    ST_CNT_LO:  r_cnt  <= WIDTH'(in_data);
                    ST_CNT_HI:  r_cnt  <= w_cnt_field;
                    default:    ;
                endcase
            end
            if (w_word_done) begin
                wr_en   <= 1'b1;
                wr_addr <= r_addr;
                wr_data <= w_word;
                r_addr  <= r_addr + WIDTH'(1);
                r_cnt   <= r_cnt - WIDTH'(1);
            end
        end
    end

    assign busy  = r_state inside {ST_ADDR_LO, ST_ADDR_HI, ST_CNT_LO, ST_CNT_HI,
                                   ST_DATA, ST_CHECK};
    assign run   = (r_state == ST_DONE);
    assign error = (r_state == ST_ERROR);

endmodule

// File: tb/tb_program_loader.sv
// Directed bench for program_loader at WIDTH=8 and WIDTH=16 (two instances, shared clock/reset).
// Expected values are hand-computed from the frame format; writes are logged at negedge.
module tb_program_loader;

    logic        clk = 1'b0;
    logic        reset;
    logic        v8,  v16;
    logic [7:0]  d8,  d16;
    logic        rdy8, rdy16;
    logic        we8,  we16;
    logic [7:0]  wa8,  wd8;
    logic [15:0] wa16, wd16;
    logic        busy8, busy16, run8, run16, err8, err16;

    int total = 0;
    int bad   = 0;

    logic [15:0] q8[$];
    logic [31:0] q16[$];

    always #5 clk = ~clk;

    program_loader #(.WIDTH(8)) u_dut8 (
        .clk(clk), .reset(reset), .in_valid(v8), .in_data(d8), .in_ready(rdy8),
        .wr_en(we8), .wr_addr(wa8), .wr_data(wd8), .busy(busy8), .run(run8), .error(err8));

    program_loader #(.WIDTH(16)) u_dut16 (
        .clk(clk), .reset(reset), .in_valid(v16), .in_data(d16), .in_ready(rdy16),
        .wr_en(we16), .wr_addr(wa16), .wr_data(wd16), .busy(busy16), .run(run16), .error(err16));

    always @(negedge clk) begin
        if (we8)  q8.push_back({wa8, wd8});
        if (we16) q16.push_back({wa16, wd16});
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Present one byte for one cycle; returns #1 after the transfer edge.
    task automatic send(input bit w16, input logic [7:0] b);
        if (w16) begin v16 = 1'b1; d16 = b; end
        else     begin v8  = 1'b1; d8  = b; end
        @(posedge clk);
        #1;
        v8  = 1'b0;
        v16 = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        idle(2);
        reset = 1'b0;
        idle(1);
        q8.delete();
        q16.delete();
    endtask

    initial begin
        reset = 1'b0; v8 = 1'b0; v16 = 1'b0; d8 = 8'h00; d16 = 8'h00;
        #2;
        do_reset();

        // Reset state
        check("rst_ready", {31'd0, rdy8}, 32'd1);
        check("rst_wr_en", {31'd0, we8}, 32'd0);
        check("rst_wr_addr", {16'd0, wa16}, 32'd0);
        check("rst_wr_data", {24'd0, wd8}, 32'd0);
        check("rst_flags", {29'd0, busy8, run8, err8}, 32'd0);

        // W8 good frame: A5 64 00 02 00 11 22 99
        send(0, 8'hA5); send(0, 8'h64);
        check("w8_busy", {31'd0, busy8}, 32'd1);
        send(0, 8'h00); send(0, 8'h02); send(0, 8'h00);
        send(0, 8'h11);
        check("w8_w0", {15'd0, we8, wa8, wd8}, {15'd0, 1'b1, 8'h64, 8'h11});
        send(0, 8'h22);
        check("w8_w1", {15'd0, we8, wa8, wd8}, {15'd0, 1'b1, 8'h65, 8'h22});
        send(0, 8'h99);
        check("w8_done", {28'd0, run8, err8, busy8, rdy8}, {28'd0, 4'b1000});
        send(0, 8'hA5); send(0, 8'h00);
        idle(2);
        check("w8_nwrites", q8.size(), 32'd2);
        check("w8_run_sticky", {31'd0, run8}, 32'd1);

        // W16 good frame: A5 10 00 01 00 34 12 57
        send(1, 8'hA5); send(1, 8'h10); send(1, 8'h00); send(1, 8'h01); send(1, 8'h00);
        send(1, 8'h34);
        check("w16_no_early", {31'd0, we16}, 32'd0);
        send(1, 8'h12);
        check("w16_w0", {15'd0, we16, wa16, wd16}, {15'd0, 1'b1, 16'h0010, 16'h1234});
        send(1, 8'h57);
        check("w16_done", {31'd0, run16}, 32'd1);
        check("w16_nwrites", q16.size(), 32'd1);

        // W8 bad checksum, then a correct frame
        do_reset();
        send(0, 8'hA5); send(0, 8'h64); send(0, 8'h00); send(0, 8'h02); send(0, 8'h00);
        send(0, 8'h11); send(0, 8'h22); send(0, 8'h98);
        check("bad_flags", {29'd0, run8, err8, rdy8}, {29'd0, 3'b011});
        check("bad_writes", q8.size(), 32'd2);
        send(0, 8'h33);
        check("bad_drop", {30'd0, err8, busy8}, {30'd0, 2'b10});
        send(0, 8'hA5);
        check("bad_restart", {30'd0, err8, busy8}, {30'd0, 2'b01});
        send(0, 8'h64); send(0, 8'h00); send(0, 8'h02); send(0, 8'h00);
        send(0, 8'h11); send(0, 8'h22); send(0, 8'h99);
        check("bad_recover", {30'd0, run8, err8}, {30'd0, 2'b10});
        check("bad_total_writes", q8.size(), 32'd4);

        // W16 noise then zero-count frame: 00 FF A5 00 00 00 00 00
        send(1, 8'h00); send(1, 8'hFF);
        check("noise_idle", {31'd0, busy16}, 32'd0);
        send(1, 8'hA5); send(1, 8'h00); send(1, 8'h00); send(1, 8'h00); send(1, 8'h00);
        check("zero_check_busy", {31'd0, busy16}, 32'd1);
        send(1, 8'h00);
        idle(1);
        check("zero_run", {31'd0, run16}, 32'd1);
        check("zero_nwrites", q16.size(), 32'd0);

        // W8 reset right after the first data byte completes a word
        do_reset();
        send(0, 8'hA5); send(0, 8'h64); send(0, 8'h00); send(0, 8'h02); send(0, 8'h00);
        send(0, 8'h11);
        reset = 1'b1;
        #1;
        check("mid_rst_outs", {7'd0, we8, wa8, wd8, busy8, run8, err8, rdy8},
              {7'd0, 1'b0, 8'h00, 8'h00, 4'b0001});
        idle(2);
        reset = 1'b0;
        idle(1);
        check("mid_rst_nowrite", q8.size(), 32'd0);
        send(0, 8'hA5); send(0, 8'h64); send(0, 8'h00); send(0, 8'h02); send(0, 8'h00);
        send(0, 8'h11); send(0, 8'h22); send(0, 8'h99);
        check("resend_run", {31'd0, run8}, 32'd1);
        check("resend_n", q8.size(), 32'd2);
        if (q8.size() == 2) begin
            check("resend_w0", {16'd0, q8[0]}, 32'h6411);
            check("resend_w1", {16'd0, q8[1]}, 32'h6522);
        end

        // W16 address wrap: A5 FF FF 02 00 01 00 02 00, chk = 0x203 mod 256 = 03
        send(1, 8'hA5); send(1, 8'hFF); send(1, 8'hFF); send(1, 8'h02); send(1, 8'h00);
        send(1, 8'h01); send(1, 8'h00);
        send(1, 8'h02);
        check("wrap_gap", {31'd0, we16}, 32'd0);
        send(1, 8'h00);
        send(1, 8'h03);
        check("wrap_run", {31'd0, run16}, 32'd1);
        check("wrap_n", q16.size(), 32'd2);
        if (q16.size() == 2) begin
            check("wrap_w0", q16[0], 32'hFFFF_0001);
            check("wrap_w1", q16[1], 32'h0000_0002);
        end

        // W16 scenario 2 with random idle gaps, then bytes after DONE
        do_reset();
        begin
            logic [7:0] fr[8];
            fr = '{8'hA5, 8'h10, 8'h00, 8'h01, 8'h00, 8'h34, 8'h12, 8'h57};
            for (int i = 0; i < 8; i++) begin
                idle($urandom_range(0, 3));
                send(1, fr[i]);
            end
        end
        check("gap_run", {31'd0, run16}, 32'd1);
        check("gap_n", q16.size(), 32'd1);
        if (q16.size() == 1) check("gap_w0", q16[0], 32'h0010_1234);
        check("gap_ready_done", {31'd0, rdy16}, 32'd0);
        send(1, 8'hA5); send(1, 8'h10); send(1, 8'h00); send(1, 8'h01);
        send(1, 8'h00); send(1, 8'h34); send(1, 8'h12);
        idle(2);
        check("after_done_n", q16.size(), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
